// File: rtl/sram_bus_arbiter_if.sv
// Request/ack bundle between the IF/MEM pipeline stages and the SRAM arbiter.
// Signal suffixes follow the arbiter's view: _i flows into it, _o flows out of it.
interface sram_bus_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              inst_req_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic              inst_ack_o;
  logic [DATA_W-1:0] inst_rdata_o;

  logic              data_req_i;
  logic              data_we_i;
  logic [3:0]        data_be_n_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic              data_ack_o;
  logic [DATA_W-1:0] data_rdata_o;

  modport master (
    output inst_req_i, inst_addr_i,
    input  inst_ack_o, inst_rdata_o,
    output data_req_i, data_we_i, data_be_n_i, data_addr_i, data_wdata_i,
    input  data_ack_o, data_rdata_o
  );

  modport slave (
    input  inst_req_i, inst_addr_i,
    output inst_ack_o, inst_rdata_o,
    input  data_req_i, data_we_i, data_be_n_i, data_addr_i, data_wdata_i,
    output data_ack_o, data_rdata_o
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one asynchronous 32-bit SRAM bank between instruction fetch (read-only) and
// the data port. One-cycle reads, two-cycle writes, one-cycle ack pulse per access.
module sram_bus_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  sram_bus_arbiter_if.slave   bus,
  output logic                sram_ce_n_o,
  output logic                sram_oe_n_o,
  output logic                sram_we_n_o,
  output logic [3:0]          sram_be_n_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  inout  wire  [DATA_W-1:0]   sram_data_io
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    WRITE_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic              owner_data_q, owner_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_n_q, be_n_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              inst_ack_q, inst_ack_d;
  logic              data_ack_q, data_ack_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic ack_cycle;
  logic inst_elig;
  logic data_elig;
  logic grant_data;
  logic grant_inst;
  logic drive_bus;

  // An ack cycle is never a grant cycle: the acked port's request is still held,
  // and keeping the turnaround uniform gives the fixed 3/4-cycle access period.
  assign ack_cycle  = inst_ack_q | data_ack_q;
  assign inst_elig  = bus.inst_req_i & ~ack_cycle;
  assign data_elig  = bus.data_req_i & ~ack_cycle;
  assign grant_data = (state_q == IDLE) & data_elig &
                      ((starve_q < STARVE_LIM) | ~inst_elig);
  assign grant_inst = (state_q == IDLE) & inst_elig & ~grant_data;

  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_n_d       = be_n_q;
    wdata_d      = wdata_q;
    inst_ack_d   = 1'b0;
    data_ack_d   = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_data) begin
          owner_data_d = 1'b1;
          addr_d       = bus.data_addr_i;
          we_d         = bus.data_we_i;
          be_n_d       = bus.data_be_n_i;
          wdata_d      = bus.data_wdata_i;
          state_d      = bus.data_we_i ? WRITE : READ;
        end else if (grant_inst) begin
          owner_data_d = 1'b0;
          addr_d       = bus.inst_addr_i;
          we_d         = 1'b0;
          be_n_d       = 4'b0000;
          state_d      = READ;
        end
      end
      READ: begin
        if (owner_data_q) begin
          data_rdata_d = sram_data_io;
          data_ack_d   = 1'b1;
        end else begin
          inst_rdata_d = sram_data_io;
          inst_ack_d   = 1'b1;
        end
        state_d = IDLE;
      end
      WRITE: begin
        state_d = WRITE_HOLD;
      end
      WRITE_HOLD: begin
        data_ack_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.inst_req_i || grant_inst) begin
      starve_d = '0;
    end else if (grant_data && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Pins decode from state and latched access registers only.
  always_comb begin
    sram_ce_n_o = 1'b1;
    sram_oe_n_o = 1'b1;
    sram_we_n_o = 1'b1;
    sram_be_n_o = 4'b1111;
    sram_addr_o = '0;
    drive_bus   = 1'b0;
    case (state_q)
      READ: begin
        sram_ce_n_o = 1'b0;
        sram_oe_n_o = 1'b0;
        sram_be_n_o = 4'b0000;
        sram_addr_o = addr_q;
      end
      WRITE: begin
        sram_ce_n_o = 1'b0;
        sram_we_n_o = 1'b0;
        sram_be_n_o = be_n_q;
        sram_addr_o = addr_q;
        drive_bus   = 1'b1;
      end
      WRITE_HOLD: begin
        sram_ce_n_o = 1'b0;
        sram_be_n_o = be_n_q;
        sram_addr_o = addr_q;
        drive_bus   = 1'b1;
      end
      default: begin
        drive_bus = 1'b0;
      end
    endcase
  end

  assign sram_data_io = drive_bus ? wdata_q : {DATA_W{1'bz}};

  assign bus.inst_ack_o   = inst_ack_q;
  assign bus.inst_rdata_o = inst_rdata_q;
  assign bus.data_ack_o   = data_ack_q;
  assign bus.data_rdata_o = data_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_data_q <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_n_q       <= 4'b1111;
      wdata_q      <= '0;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      be_n_q       <= be_n_d;
      wdata_q      <= wdata_d;
      inst_ack_q   <= inst_ack_d;
      data_ack_q   <= data_ack_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      starve_q     <= starve_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with a behavioural asynchronous SRAM model.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;
  logic [19:0] sram_addr;
  wire  [31:0] sram_data;

  logic [31:0] mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_val = '0;

  int n_checks = 0;
  int n_errors = 0;

  sram_bus_arbiter_if bus ();

  sram_bus_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .sram_ce_n_o  (sram_ce_n),
    .sram_oe_n_o  (sram_oe_n),
    .sram_we_n_o  (sram_we_n),
    .sram_be_n_o  (sram_be_n),
    .sram_addr_o  (sram_addr),
    .sram_data_io (sram_data)
  );

  always #5 clk = ~clk;

  assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[11:0]] : 32'bz;

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_val;
    end else if (!sram_ce_n && !sram_we_n) begin
      for (int i = 0; i < 4; i++)
        if (!sram_be_n[i]) mem[sram_addr[11:0]][8*i +: 8] <= sram_data[8*i +: 8];
    end
  end

  typedef struct {
    logic        is_data;
    logic        we;
    logic [3:0]  be_n;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_init;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mem;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic bit pins_idle();
    return sram_ce_n === 1'b1 && sram_oe_n === 1'b1 && sram_we_n === 1'b1 &&
           sram_be_n === 4'b1111 && sram_addr === 20'h0;
  endfunction

  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_val = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int lat, acks, other_acks, we_low, drv;
    string tag;
    tag = $sformatf("vec%0d", k);
    preload(v.addr[11:0], v.mem_init);
    @(negedge clk);
    if (v.is_data) begin
      bus.data_req_i = 1'b1; bus.data_we_i = v.we; bus.data_be_n_i = v.be_n;
      bus.data_addr_i = v.addr; bus.data_wdata_i = v.wdata;
    end else begin
      bus.inst_req_i = 1'b1; bus.inst_addr_i = v.addr;
    end
    lat = 0; acks = 0; other_acks = 0; we_low = 0; drv = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (sram_we_n === 1'b0) we_low++;
      if (sram_ce_n === 1'b0 && sram_oe_n === 1'b1) drv++;
      if (n == 1) begin
        chk({tag, "_addr_t1"}, {12'h0, sram_addr}, {12'h0, v.addr});
        chk({tag, "_oe_n_t1"}, {31'h0, sram_oe_n}, {31'h0, v.we});
        chk({tag, "_be_n_t1"}, {28'h0, sram_be_n}, v.we ? {28'h0, v.be_n} : 32'h0);
      end
      if ((v.is_data ? bus.data_ack_o : bus.inst_ack_o) === 1'b1) begin
        acks++;
        if (lat == 0) lat = n;
        bus.data_req_i = 1'b0; bus.inst_req_i = 1'b0;
      end
      if ((v.is_data ? bus.inst_ack_o : bus.data_ack_o) === 1'b1) other_acks++;
    end
    chk({tag, "_latency"}, lat, v.exp_lat);
    chk({tag, "_ack_count"}, acks, 1);
    chk({tag, "_other_ack"}, other_acks, 0);
    chk({tag, "_we_low_cycles"}, we_low, v.we ? 1 : 0);
    chk({tag, "_bus_drive_cycles"}, drv, v.we ? 2 : 0);
    if (v.we) chk({tag, "_mem"}, mem[v.addr[11:0]], v.exp_mem);
    else      chk({tag, "_rdata"}, v.is_data ? bus.data_rdata_o : bus.inst_rdata_o, v.exp_rdata);
  endtask

  // Both ports (or fetch alone) hold read requests; collect 10 acks and their order.
  task automatic run_order(input string tag, input bit with_data, input string exp_order);
    string order;
    int both, last, bad_gap, first;
    order = ""; both = 0; last = 0; bad_gap = 0; first = 0;
    preload(12'h040, 32'h0D0D0D0D);
    preload(12'h041, 32'h01010101);
    @(negedge clk);
    bus.inst_req_i = 1'b1; bus.inst_addr_i = 20'h00041;
    bus.data_req_i = with_data; bus.data_we_i = 1'b0;
    bus.data_be_n_i = 4'hF; bus.data_addr_i = 20'h00040;
    for (int n = 1; n <= 60 && order.len() < 10; n++) begin
      @(negedge clk);
      if (bus.data_ack_o === 1'b1 && bus.inst_ack_o === 1'b1) both++;
      if (bus.data_ack_o === 1'b1 || bus.inst_ack_o === 1'b1) begin
        order = {order, (bus.data_ack_o === 1'b1) ? "D" : "I"};
        if (last == 0) first = n;
        else if (n - last != 3) bad_gap++;
        last = n;
      end
    end
    bus.inst_req_i = 1'b0; bus.data_req_i = 1'b0;
    n_checks++;
    if (order != exp_order) begin
      n_errors++;
      $display("FAIL %s_order: got %s, expected %s", tag, order, exp_order);
    end
    chk({tag, "_both_acks"}, both, 0);
    chk({tag, "_gap_not_3"}, bad_gap, 0);
    chk({tag, "_first_ack"}, first, 2);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int bad;
    bus.inst_req_i = 1'b0; bus.inst_addr_i = '0;
    bus.data_req_i = 1'b0; bus.data_we_i = 1'b0; bus.data_be_n_i = 4'hF;
    bus.data_addr_i = '0; bus.data_wdata_i = '0;

    vecs[0] = '{1'b0, 1'b0, 4'hF,    20'h00010, 32'h0,        32'h3C011234, 32'h3C011234, 32'h3C011234, 2};
    vecs[1] = '{1'b1, 1'b1, 4'b1110, 20'h00200, 32'hABABABAB, 32'h11223344, 32'h0,        32'h112233AB, 3};
    vecs[2] = '{1'b1, 1'b0, 4'hF,    20'h00123, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2};
    vecs[3] = '{1'b1, 1'b1, 4'b0000, 20'h00201, 32'h01020304, 32'hFFFFFFFF, 32'h0,        32'h01020304, 3};
    vecs[4] = '{1'b1, 1'b1, 4'b0101, 20'h00202, 32'hAABBCCDD, 32'h11223344, 32'h0,        32'hAA22CC44, 3};
    vecs[5] = '{1'b1, 1'b1, 4'b1111, 20'h00203, 32'h99999999, 32'h55667788, 32'h0,        32'h55667788, 3};
    vecs[6] = '{1'b0, 1'b0, 4'hF,    20'hFFFFF, 32'h0,        32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 2};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_pins_idle", {31'h0, pins_idle()}, 32'h1);
    chk("reset_inst_ack", {31'h0, bus.inst_ack_o}, 32'h0);
    chk("reset_data_ack", {31'h0, bus.data_ack_o}, 32'h0);
    chk("reset_inst_rdata", bus.inst_rdata_o, 32'h0);
    chk("reset_data_rdata", bus.data_rdata_o, 32'h0);

    for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);
    chk("data_rdata_held", bus.data_rdata_o, 32'hDEADBEEF);
    chk("inst_rdata_held", bus.inst_rdata_o, 32'h0BADF00D);

    run_order("starve", 1'b1, "DDDDIDDDDI");
    run_order("inst_only", 1'b0, "IIIIIIIIII");

    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!pins_idle() || bus.inst_ack_o !== 1'b0 || bus.data_ack_o !== 1'b0) bad++;
    end
    chk("idle_20_cycles", bad, 0);
    run_order("starve_again", 1'b1, "DDDDIDDDDI");

    preload(12'h300, 32'h12345678);
    @(negedge clk);
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_be_n_i = 4'b0000;
    bus.data_addr_i = 20'h00300; bus.data_wdata_i = 32'hCAFEF00D;
    @(negedge clk);
    chk("rstmid_in_write_we_n", {31'h0, sram_we_n}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_pins_idle", {31'h0, pins_idle()}, 32'h1);
    chk("rstmid_data_ack", {31'h0, bus.data_ack_o}, 32'h0);
    bus.data_req_i = 1'b0;
    rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.data_ack_o !== 1'b0 || !pins_idle()) bad++;
    end
    chk("rstmid_no_ack_after", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
